decode_stage: RTL and testbench

- Registered, handshaked RV32I instruction decode stage, with optional M-extension decode, sitting between fetch (IF/ID) and execute in the 5-stage pipeline.
- Adds the following: a valid/ready pipeline boundary with a 2-entry skid buffer, flush, full legality checking, correct per-format immediates (J, I, S, B, U, shamt), an op-class output and saturating decode counters.
- Keeps the uppercase ASCII mnemonic output used by the VGA debug display.

---
 rtl/decode_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I (+ optional M) decode stage: combinational decode of the fetched word,
// registered into a main/skid buffer pair behind a valid/ready handshake.
package decode_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [3:0]  op_class;
        logic        illegal;
    } dec_t;

    localparam logic [3:0] CLS_R_ALU   = 4'd0;
    localparam logic [3:0] CLS_I_ALU   = 4'd1;
    localparam logic [3:0] CLS_LOAD    = 4'd2;
    localparam logic [3:0] CLS_STORE   = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_JAL     = 4'd5;
    localparam logic [3:0] CLS_JALR    = 4'd6;
    localparam logic [3:0] CLS_LUI     = 4'd7;
    localparam logic [3:0] CLS_AUIPC   = 4'd8;
    localparam logic [3:0] CLS_MULDIV  = 4'd9;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit          ENABLE_M = 1'b0,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STR_W    = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [31:0]      imm,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [3:0]       op_class,
    output logic             illegal,
    output logic [STR_W-1:0] decode_str,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    localparam int unsigned MN_W = 56;
    localparam logic [STR_W-1:0] RESET_STR = STR_W'("RESET");
    localparam logic [MN_W-1:0]  UNK_STR   = MN_W'("UNKNOWN");

    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [31:0]      imm_i;
    logic [31:0]      imm_s;
    logic [31:0]      imm_b;
    logic [31:0]      imm_j;
    logic [31:0]      imm_u;
    logic [31:0]      imm_sh;
    logic [3:0]       cls_c;
    logic [MN_W-1:0]  mn_c;
    dec_t             dec_c;
    logic [STR_W-1:0] str_c;

    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    // Mnemonic and class; an encoding is legal exactly when it names a mnemonic.
    always_comb begin
        cls_c = CLS_ILLEGAL;
        mn_c  = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                OP_R: begin
                    if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                        cls_c = CLS_R_ALU;
                        case (f3)
                            3'd0: mn_c = f7[5] ? MN_W'("SUB") : MN_W'("ADD");
                            3'd1: mn_c = MN_W'("SLL");
                            3'd2: mn_c = MN_W'("SLT");
                            3'd3: mn_c = MN_W'("SLTU");
                            3'd4: mn_c = MN_W'("XOR");
                            3'd5: mn_c = f7[5] ? MN_W'("SRA") : MN_W'("SRL");
                            3'd6: mn_c = MN_W'("OR");
                            3'd7: mn_c = MN_W'("AND");
                        endcase
                    end else if (ENABLE_M && f7 == 7'h01) begin
                        cls_c = CLS_MULDIV;
                        case (f3)
                            3'd0: mn_c = MN_W'("MUL");
                            3'd1: mn_c = MN_W'("MULH");
                            3'd2: mn_c = MN_W'("MULHSU");
                            3'd3: mn_c = MN_W'("MULHU");
                            3'd4: mn_c = MN_W'("DIV");
                            3'd5: mn_c = MN_W'("DIVU");
                            3'd6: mn_c = MN_W'("REM");
                            3'd7: mn_c = MN_W'("REMU");
                        endcase
                    end
                end
                OP_I: begin
                    case (f3)
                        3'd0: mn_c = MN_W'("ADDI");
                        3'd1: mn_c = (f7 == 7'h00) ? MN_W'("SLLI") : '0;
                        3'd2: mn_c = MN_W'("SLTI");
                        3'd3: mn_c = MN_W'("SLTIU");
                        3'd4: mn_c = MN_W'("XORI");
                        3'd5: mn_c = (f7 == 7'h00) ? MN_W'("SRLI") :
                                     (f7 == 7'h20) ? MN_W'("SRAI") : '0;
                        3'd6: mn_c = MN_W'("ORI");
                        3'd7: mn_c = MN_W'("ANDI");
                    endcase
                    cls_c = (mn_c != '0) ? CLS_I_ALU : CLS_ILLEGAL;
                end
                OP_LOAD: begin
                    case (f3)
                        3'd0:    mn_c = MN_W'("LB");
                        3'd1:    mn_c = MN_W'("LH");
                        3'd2:    mn_c = MN_W'("LW");
                        3'd4:    mn_c = MN_W'("LBU");
                        3'd5:    mn_c = MN_W'("LHU");
                        default: mn_c = '0;
                    endcase
                    cls_c = (mn_c != '0) ? CLS_LOAD : CLS_ILLEGAL;
                end
                OP_STORE: begin
                    case (f3)
                        3'd0:    mn_c = MN_W'("SB");
                        3'd1:    mn_c = MN_W'("SH");
                        3'd2:    mn_c = MN_W'("SW");
                        default: mn_c = '0;
                    endcase
                    cls_c = (mn_c != '0) ? CLS_STORE : CLS_ILLEGAL;
                end
                OP_BRANCH: begin
                    case (f3)
                        3'd0:    mn_c = MN_W'("BEQ");
                        3'd1:    mn_c = MN_W'("BNE");
                        3'd4:    mn_c = MN_W'("BLT");
                        3'd5:    mn_c = MN_W'("BGE");
                        3'd6:    mn_c = MN_W'("BLTU");
                        3'd7:    mn_c = MN_W'("BGEU");
                        default: mn_c = '0;
                    endcase
                    cls_c = (mn_c != '0) ? CLS_BRANCH : CLS_ILLEGAL;
                end
                OP_JAL: begin
                    cls_c = CLS_JAL;
                    mn_c  = MN_W'("JAL");
                end
                OP_JALR: begin
                    if (f3 == 3'd0) begin
                        cls_c = CLS_JALR;
                        mn_c  = MN_W'("JALR");
                    end
                end
                OP_LUI: begin
                    cls_c = CLS_LUI;
                    mn_c  = MN_W'("LUI");
                end
                OP_AUIPC: begin
                    cls_c = CLS_AUIPC;
                    mn_c  = MN_W'("AUIPC");
                end
                default: cls_c = CLS_ILLEGAL;
            endcase
        end
    end

    // Per-format field selection; absent fields and illegal entries read as 0.
    always_comb begin
        dec_c          = '0;
        dec_c.pc       = in_pc;
        dec_c.opcode   = in_instr[6:0];
        dec_c.func3    = f3;
        dec_c.op_class = cls_c;
        str_c          = STR_W'(mn_c);
        case (cls_c)
            CLS_R_ALU, CLS_MULDIV: begin
                dec_c.rd    = in_instr[11:7];
                dec_c.rs1   = in_instr[19:15];
                dec_c.rs2   = in_instr[24:20];
                dec_c.func7 = f7;
            end
            CLS_I_ALU: begin
                dec_c.rd  = in_instr[11:7];
                dec_c.rs1 = in_instr[19:15];
                dec_c.imm = (f3 == 3'd1 || f3 == 3'd5) ? imm_sh : imm_i;
            end
            CLS_LOAD, CLS_JALR: begin
                dec_c.rd  = in_instr[11:7];
                dec_c.rs1 = in_instr[19:15];
                dec_c.imm = imm_i;
            end
            CLS_STORE: begin
                dec_c.rs1 = in_instr[19:15];
                dec_c.rs2 = in_instr[24:20];
                dec_c.imm = imm_s;
            end
            CLS_BRANCH: begin
                dec_c.rs1 = in_instr[19:15];
                dec_c.rs2 = in_instr[24:20];
                dec_c.imm = imm_b;
            end
            CLS_JAL: begin
                dec_c.rd  = in_instr[11:7];
                dec_c.imm = imm_j;
            end
            CLS_LUI, CLS_AUIPC: begin
                dec_c.rd  = in_instr[11:7];
                dec_c.imm = imm_u;
            end
            default: begin
                dec_c.illegal = 1'b1;
                str_c         = STR_W'(UNK_STR);
            end
        endcase
    end

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_ready_q, in_ready_d;
    dec_t             main_q, main_d;
    dec_t             skid_q, skid_d;
    logic [STR_W-1:0] main_str_q, main_str_d;
    logic [STR_W-1:0] skid_str_q, skid_str_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             accept;
    logic             handoff;

    assign accept  = in_valid & in_ready_q;
    assign handoff = main_v_q & out_ready;

    // Buffer movement: skid refills main on handoff; flush drops everything.
    always_comb begin
        main_v_d   = main_v_q;
        skid_v_d   = skid_v_q;
        main_d     = main_q;
        skid_d     = skid_q;
        main_str_d = main_str_q;
        skid_str_d = skid_str_q;
        dec_cnt_d  = dec_cnt_q;
        ill_cnt_d  = ill_cnt_q;

        if (handoff) begin
            if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_W'(1);
            if (main_q.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (handoff) begin
            if (skid_v_q) begin
                main_d     = skid_q;
                main_str_d = skid_str_q;
                main_v_d   = 1'b1;
                skid_v_d   = accept;
                skid_d     = accept ? dec_c : skid_q;
                skid_str_d = accept ? str_c : skid_str_q;
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_d     = dec_c;
                    main_str_d = str_c;
                end
            end
        end else if (accept) begin
            if (!main_v_q) begin
                main_v_d   = 1'b1;
                main_d     = dec_c;
                main_str_d = str_c;
            end else begin
                skid_v_d   = 1'b1;
                skid_d     = dec_c;
                skid_str_d = str_c;
            end
        end

        in_ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            main_str_q <= RESET_STR;
            skid_str_q <= RESET_STR;
            dec_cnt_q  <= '0;
            ill_cnt_q  <= '0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_str_q <= main_str_d;
            skid_str_q <= skid_str_d;
            dec_cnt_q  <= dec_cnt_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_v_q;
    assign out_pc     = main_q.pc;
    assign rd         = main_q.rd;
    assign rs1        = main_q.rs1;
    assign rs2        = main_q.rs2;
    assign imm        = main_q.imm;
    assign opcode     = main_q.opcode;
    assign func3      = main_q.func3;
    assign func7      = main_q.func7;
    assign op_class   = main_q.op_class;
    assign illegal    = main_q.illegal;
    assign decode_str = main_str_q;
    assign dec_count  = dec_cnt_q;
    assign ill_count  = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (no M / 16-bit counters, and M / 2-bit
// counters) share stimulus and are checked against a table-driven model.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] out_pc_a, imm_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [6:0]  opcode_a, func7_a;
    logic [2:0]  func3_a;
    logic [3:0]  op_class_a;
    logic [79:0] str_a;
    logic [15:0] dec_cnt_a, ill_cnt_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [31:0] out_pc_b, imm_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [6:0]  opcode_b, func7_b;
    logic [2:0]  func3_b;
    logic [3:0]  op_class_b;
    logic [63:0] str_b;
    logic [1:0]  dec_cnt_b, ill_cnt_b;

    decode_stage #(.ENABLE_M(1'b0), .CNT_W(16), .STR_W(80)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .imm(imm_a),
        .opcode(opcode_a), .func3(func3_a), .func7(func7_a),
        .op_class(op_class_a), .illegal(illegal_a), .decode_str(str_a),
        .dec_count(dec_cnt_a), .ill_count(ill_cnt_a)
    );

    decode_stage #(.ENABLE_M(1'b1), .CNT_W(2), .STR_W(64)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
        .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b),
        .opcode(opcode_b), .func3(func3_b), .func7(func7_b),
        .op_class(op_class_b), .illegal(illegal_b), .decode_str(str_b),
        .dec_count(dec_cnt_b), .ill_count(ill_cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: pending entries as {pc, instr}, oldest first.
    logic [63:0] q[$];
    bit          in_rdy_m;
    int          cnt_a, ill_a, cnt_b, ill_b;
    string       tbl [logic [16:0]];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] key_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h33) return {op, w[14:12], w[31:25]};
        if (op == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) return {op, w[14:12], w[31:25]};
        if (op == 7'h6F || op == 7'h37 || op == 7'h17) return {op, 10'h0};
        return {op, w[14:12], 7'h0};
    endfunction

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input string mn);
        tbl[{op, f3, f7}] = mn;
    endtask

    task automatic init_tables();
        string r[8];
        string m[8];
        r = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        m = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};
        for (int i = 0; i < 8; i++) begin
            add(7'h33, 3'(i), 7'h00, r[i]);
            add(7'h33, 3'(i), 7'h01, m[i]);
        end
        add(7'h33, 3'd0, 7'h20, "SUB");
        add(7'h33, 3'd5, 7'h20, "SRA");
        add(7'h13, 3'd0, 7'h00, "ADDI");  add(7'h13, 3'd2, 7'h00, "SLTI");
        add(7'h13, 3'd3, 7'h00, "SLTIU"); add(7'h13, 3'd4, 7'h00, "XORI");
        add(7'h13, 3'd6, 7'h00, "ORI");   add(7'h13, 3'd7, 7'h00, "ANDI");
        add(7'h13, 3'd1, 7'h00, "SLLI");  add(7'h13, 3'd5, 7'h00, "SRLI");
        add(7'h13, 3'd5, 7'h20, "SRAI");
        add(7'h03, 3'd0, 7'h00, "LB");  add(7'h03, 3'd1, 7'h00, "LH");
        add(7'h03, 3'd2, 7'h00, "LW");  add(7'h03, 3'd4, 7'h00, "LBU");
        add(7'h03, 3'd5, 7'h00, "LHU");
        add(7'h23, 3'd0, 7'h00, "SB");  add(7'h23, 3'd1, 7'h00, "SH");
        add(7'h23, 3'd2, 7'h00, "SW");
        add(7'h63, 3'd0, 7'h00, "BEQ"); add(7'h63, 3'd1, 7'h00, "BNE");
        add(7'h63, 3'd4, 7'h00, "BLT"); add(7'h63, 3'd5, 7'h00, "BGE");
        add(7'h63, 3'd6, 7'h00, "BLTU"); add(7'h63, 3'd7, 7'h00, "BGEU");
        add(7'h67, 3'd0, 7'h00, "JALR");
        add(7'h6F, 3'd0, 7'h00, "JAL");
        add(7'h37, 3'd0, 7'h00, "LUI");
        add(7'h17, 3'd0, 7'h00, "AUIPC");
    endtask

    function automatic string mnem(input logic [31:0] w, input bit en_m);
        logic [16:0] k;
        k = key_of(w);
        if (!tbl.exists(k)) return "";
        if (w[6:0] == 7'h33 && w[31:25] == 7'h01 && !en_m) return "";
        return tbl[k];
    endfunction

    function automatic logic [79:0] str_bits(input string s);
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[71:0], s[i]};
        return v;
    endfunction

    // Expected {pc, rd, rs1, rs2, imm, opcode, func3, func7, op_class, illegal}.
    task automatic ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit en_m,
                              output logic [100:0] f, output string mn);
        int s, t, cls;
        logic [31:0] im;
        logic [4:0]  xd, x1, x2;
        logic [6:0]  f7o;
        mn = mnem(w, en_m);
        if (mn == "") begin
            mn = "UNKNOWN";
            f  = {pc, 15'b0, 32'b0, w[6:0], w[14:12], 7'b0, 4'hF, 1'b1};
            return;
        end
        s = w;
        case (w[6:0])
            7'h33:   cls = (w[31:25] == 7'h01) ? 9 : 0;
            7'h13:   cls = 1;
            7'h03:   cls = 2;
            7'h23:   cls = 3;
            7'h63:   cls = 4;
            7'h6F:   cls = 5;
            7'h67:   cls = 6;
            7'h37:   cls = 7;
            default: cls = 8;
        endcase
        xd  = (cls == 3 || cls == 4) ? 5'd0 : w[11:7];
        x1  = (cls == 5 || cls == 7 || cls == 8) ? 5'd0 : w[19:15];
        x2  = (cls == 0 || cls == 3 || cls == 4 || cls == 9) ? w[24:20] : 5'd0;
        f7o = (cls == 0 || cls == 9) ? w[31:25] : 7'd0;
        case (cls)
            1: begin
                if (mn == "SLLI" || mn == "SRLI" || mn == "SRAI") im = (w >> 20) & 32'h1F;
                else begin t = s >>> 20; im = t; end
            end
            2, 6: begin t = s >>> 20; im = t; end
            3: begin t = s >>> 25; im = (t << 5) | ((w >> 7) & 32'h1F); end
            4: begin
                t  = s >>> 31;
                im = (t << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
                   | (((w >> 8) & 32'hF) << 1);
            end
            5: begin
                t  = s >>> 31;
                im = (t << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11)
                   | (((w >> 21) & 32'h3FF) << 1);
            end
            7, 8:    im = w & 32'hFFFFF000;
            default: im = 32'h0;
        endcase
        f = {pc, xd, x1, x2, im, w[6:0], w[14:12], f7o, 4'(cls), 1'b0};
    endtask

    task automatic check_outputs();
        logic [100:0] fe;
        logic [63:0]  head;
        string        mn;
        check_eq("a_in_ready",  128'(in_ready_a),  128'(in_rdy_m));
        check_eq("b_in_ready",  128'(in_ready_b),  128'(in_rdy_m));
        check_eq("a_out_valid", 128'(out_valid_a), 128'(q.size() > 0));
        check_eq("b_out_valid", 128'(out_valid_b), 128'(q.size() > 0));
        check_eq("a_dec_count", 128'(dec_cnt_a), 128'(cnt_a));
        check_eq("a_ill_count", 128'(ill_cnt_a), 128'(ill_a));
        check_eq("b_dec_count", 128'(dec_cnt_b), 128'(cnt_b));
        check_eq("b_ill_count", 128'(ill_cnt_b), 128'(ill_b));
        if (q.size() > 0) begin
            head = q[0];
            ref_decode(head[31:0], head[63:32], 1'b0, fe, mn);
            check_eq("a_fields", 128'({out_pc_a, rd_a, rs1_a, rs2_a, imm_a, opcode_a, func3_a,
                                       func7_a, op_class_a, illegal_a}), 128'(fe));
            check_eq("a_str", 128'(str_a), 128'(str_bits(mn)));
            ref_decode(head[31:0], head[63:32], 1'b1, fe, mn);
            check_eq("b_fields", 128'({out_pc_b, rd_b, rs1_b, rs2_b, imm_b, opcode_b, func3_b,
                                       func7_b, op_class_b, illegal_b}), 128'(fe));
            check_eq("b_str", 128'(str_b), 128'(str_bits(mn)));
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_rdy_m = 1'b0;
        cnt_a = 0; ill_a = 0; cnt_b = 0; ill_b = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare at the falling edge.
    task automatic cycle(input bit v, input logic [31:0] w, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit          acc, ho;
        logic [63:0] head;
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && in_rdy_m;
        ho  = (q.size() > 0) && ordy;
        if (ho) begin
            head  = q[0];
            cnt_a = (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
            cnt_b = (cnt_b < 3) ? cnt_b + 1 : cnt_b;
            if (mnem(head[31:0], 1'b0) == "") ill_a = (ill_a < 65535) ? ill_a + 1 : ill_a;
            if (mnem(head[31:0], 1'b1) == "") ill_b = (ill_b < 3) ? ill_b + 1 : ill_b;
        end
        if (fl) q.delete();
        else begin
            if (ho) void'(q.pop_front());
            if (acc) q.push_back({pc, w});
        end
        in_rdy_m = (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            9: w[1:0] = 2'b11;
            default: ;
        endcase
        if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1)) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_a_out_valid"}, 128'(out_valid_a), 128'(0));
        check_eq({tag, "_a_in_ready"},  128'(in_ready_a),  128'(0));
        check_eq({tag, "_a_str"},       128'(str_a),       128'(str_bits("RESET")));
        check_eq({tag, "_a_counts"},    128'({dec_cnt_a, ill_cnt_a}), 128'(0));
        check_eq({tag, "_a_fields"},    128'({rd_a, rs1_a, rs2_a, imm_a, op_class_a}), 128'(0));
        check_eq({tag, "_b_out_valid"}, 128'(out_valid_b), 128'(0));
        check_eq({tag, "_b_str"},       128'(str_b),       128'(str_bits("RESET")));
        check_eq({tag, "_b_counts"},    128'({dec_cnt_b, ill_cnt_b}), 128'(0));
    endtask

    initial begin
        init_tables();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b1;

        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        check_eq("addi_valid", 128'(out_valid_a), 128'(1));
        check_eq("addi_rd_rs1_imm", 128'({rd_a, rs1_a, imm_a}), 128'({5'd1, 5'd0, 32'd5}));
        check_eq("addi_class", 128'(op_class_a), 128'(1));
        check_eq("addi_str", 128'(str_a), 128'(str_bits("ADDI")));

        cycle(1'b1, 32'h008000EF, 32'h104, 1'b1, 1'b0);
        check_eq("jal_imm_rd", 128'({imm_a, rd_a, op_class_a}), 128'({32'd8, 5'd1, 4'd5}));
        check_eq("addi_count", 128'(dec_cnt_a), 128'(1));
        cycle(1'b1, 32'h40415193, 32'h108, 1'b1, 1'b0);
        check_eq("srai_fields", 128'({imm_a, rd_a, rs1_a}), 128'({32'd4, 5'd3, 5'd2}));
        check_eq("srai_str", 128'(str_a), 128'(str_bits("SRAI")));
        cycle(1'b1, 32'h0000A103, 32'h10C, 1'b1, 1'b0);
        check_eq("lw_fields", 128'({rd_a, rs1_a, imm_a, op_class_a}),
                 128'({5'd2, 5'd1, 32'd0, 4'd2}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("stream_count", 128'(dec_cnt_a), 128'(4));

        cycle(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        check_eq("skid_full_ready", 128'(in_ready_a), 128'(0));
        cycle(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        check_eq("stall_pc", 128'(out_pc_a), 128'(32'h200));
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'hFFFFFFFF, 32'h300, 1'b1, 1'b0);
        check_eq("ones_class", 128'(op_class_a), 128'(15));
        cycle(1'b1, 32'h02208033, 32'h304, 1'b1, 1'b0);
        check_eq("mul_a_class", 128'(op_class_a), 128'(15));
        check_eq("mul_a_str", 128'(str_a), 128'(str_bits("UNKNOWN")));
        check_eq("mul_b_class", 128'(op_class_b), 128'(9));
        check_eq("mul_b_str", 128'(str_b), 128'(str_bits("MUL")));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("ill_count_a", 128'(ill_cnt_a), 128'(2));
        check_eq("ill_count_b", 128'(ill_cnt_b), 128'(1));

        cycle(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b1);
        check_eq("flush_valid", 128'(out_valid_a), 128'(0));
        check_eq("flush_counts", 128'({dec_cnt_a, dec_cnt_b}), 128'({16'd8, 2'd3}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #2 reset = 1'b0;
                in_valid = 1'b0;
                #1 check_reset_state("mid_rst");
                model_reset();
                @(negedge clk);
                reset = 1'b1;
            end
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
